// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between NREQ
// requesters, each with a valid/ready request and a one-entry registered response.
module alu_arbiter #(
  parameter int unsigned NREQ             = 2,
  parameter int unsigned ALU_CTRL_T_WIDTH = 5,
  parameter logic [ALU_CTRL_T_WIDTH-1:0] ADD_ALU_CONTROL = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NREQ-1:0]                  req_valid_i,
  output logic [NREQ-1:0]                  req_ready_o,
  input  logic [NREQ*ALU_CTRL_T_WIDTH-1:0] req_op_i,
  input  logic [NREQ*32-1:0]               req_a_i,
  input  logic [NREQ*32-1:0]               req_b_i,
  output logic [NREQ-1:0]                  resp_valid_o,
  input  logic [NREQ-1:0]                  resp_ready_i,
  output logic [NREQ*32-1:0]               resp_result_o,
  output logic [NREQ-1:0]                  resp_bcond_o,
  output logic [ALU_CTRL_T_WIDTH-1:0]      alu_control_o,
  output logic [31:0]                      alu_a_o,
  output logic [31:0]                      alu_b_o,
  input  logic [31:0]                      alu_result_i,
  input  logic                             alu_bcond_i,
  output logic                             busy_o
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   last_grant;
  logic [PW-1:0]   win;
  logic [PW-1:0]   sidx;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            any_grant;
  int unsigned     scan;

  // A slot can take a new result when it is empty or being drained this cycle.
  assign eligible = req_valid_i & (~resp_valid_o | resp_ready_i);

  always_comb begin
    grant     = '0;
    win       = last_grant;
    any_grant = 1'b0;
    scan      = 0;
    sidx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan = 32'(last_grant) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      sidx = PW'(scan);
      if (!any_grant && eligible[sidx]) begin
        grant[sidx] = 1'b1;
        win         = sidx;
        any_grant   = 1'b1;
      end
    end
    if (rst_i || flush_i) begin
      grant     = '0;
      any_grant = 1'b0;
    end
  end

  assign req_ready_o = grant;

  always_comb begin
    alu_control_o = ADD_ALU_CONTROL;
    alu_a_o       = '0;
    alu_b_o       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_control_o = req_op_i[i*ALU_CTRL_T_WIDTH +: ALU_CTRL_T_WIDTH];
        alu_a_o       = req_a_i[i*32 +: 32];
        alu_b_o       = req_b_i[i*32 +: 32];
      end
    end
  end

  // A grant to a slot wins over its drain, so drain+refill keeps valid high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_o  <= '0;
      resp_result_o <= '0;
      resp_bcond_o  <= '0;
      last_grant    <= PW'(NREQ - 1);
    end else if (flush_i) begin
      resp_valid_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          resp_valid_o[i]         <= 1'b1;
          resp_result_o[i*32 +: 32] <= alu_result_i;
          resp_bcond_o[i]         <= alu_bcond_i;
        end else if (resp_ready_i[i]) begin
          resp_valid_o[i] <= 1'b0;
        end
      end
      if (any_grant) last_grant <= win;
    end
  end

  assign busy_o = |resp_valid_o;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with NREQ=2 and a small
// behavioural ALU standing in for the core's shared ALU.
module tb_alu_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned W = 5;

  localparam logic [W-1:0] OP_ADD = 5'b00000;
  localparam logic [W-1:0] OP_SUB = 5'b01000;
  localparam logic [W-1:0] OP_LT  = 5'b00010;
  localparam logic [W-1:0] OP_SRA = 5'b01101;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           flush_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_op_i;
  logic [N*32-1:0] req_a_i;
  logic [N*32-1:0] req_b_i;
  logic [N-1:0]   resp_valid_o;
  logic [N-1:0]   resp_ready_i;
  logic [N*32-1:0] resp_result_o;
  logic [N-1:0]   resp_bcond_o;
  logic [W-1:0]   alu_control_o;
  logic [31:0]    alu_a_o;
  logic [31:0]    alu_b_o;
  logic [31:0]    alu_result_i;
  logic           alu_bcond_i;
  logic           busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  alu_arbiter #(
    .NREQ(N),
    .ALU_CTRL_T_WIDTH(W),
    .ADD_ALU_CONTROL(OP_ADD)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_op_i(req_op_i),
    .req_a_i(req_a_i),
    .req_b_i(req_b_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o),
    .resp_bcond_o(resp_bcond_o),
    .alu_control_o(alu_control_o),
    .alu_a_o(alu_a_o),
    .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i),
    .alu_bcond_i(alu_bcond_i),
    .busy_o(busy_o)
  );

  // External ALU model
  always_comb begin
    alu_result_i = '0;
    alu_bcond_i  = 1'b0;
    case (alu_control_o)
      OP_ADD: alu_result_i = alu_a_o + alu_b_o;
      OP_SUB: begin
        alu_result_i = alu_a_o - alu_b_o;
        alu_bcond_i  = (alu_a_o == alu_b_o);
      end
      OP_LT: begin
        alu_bcond_i  = ($signed(alu_a_o) < $signed(alu_b_o));
        alu_result_i = {31'b0, alu_bcond_i};
      end
      OP_SRA: alu_result_i = $signed(alu_a_o) >>> alu_b_o[4:0];
      default: alu_result_i = alu_a_o + alu_b_o;
    endcase
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic [1:0]  vld;
    logic [1:0]  rr;
    logic [W-1:0] op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [W-1:0] op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  e_ready;
    logic [31:0] e_a;
    logic [1:0]  e_rv;
    logic [31:0] e_r0;
    logic [31:0] e_r1;
    logic [1:0]  e_bc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic rst, input logic flush,
                     input logic [1:0] vld, input logic [1:0] rr,
                     input logic [W-1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                     input logic [W-1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                     input logic [1:0] e_ready, input logic [31:0] e_a, input logic [1:0] e_rv,
                     input logic [31:0] e_r0, input logic [31:0] e_r1, input logic [1:0] e_bc);
    vec_t v;
    v.name = name; v.rst = rst; v.flush = flush; v.vld = vld; v.rr = rr;
    v.op0 = op0; v.a0 = a0; v.b0 = b0; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.e_ready = e_ready; v.e_a = e_a; v.e_rv = e_rv;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_bc = e_bc;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    rst_i        = v.rst;
    flush_i      = v.flush;
    req_valid_i  = v.vld;
    resp_ready_i = v.rr;
    req_op_i     = {v.op1, v.op0};
    req_a_i      = {v.a1, v.a0};
    req_b_i      = {v.b1, v.b0};
    #1;
    check($sformatf("%0d %s ready", idx, v.name), 32'(req_ready_o), 32'(v.e_ready));
    check($sformatf("%0d %s alu_a", idx, v.name), alu_a_o, v.e_a);
    @(posedge clk_i);
    #1;
    check($sformatf("%0d %s resp_valid", idx, v.name), 32'(resp_valid_o), 32'(v.e_rv));
    check($sformatf("%0d %s result0", idx, v.name), resp_result_o[31:0], v.e_r0);
    check($sformatf("%0d %s result1", idx, v.name), resp_result_o[63:32], v.e_r1);
    check($sformatf("%0d %s bcond", idx, v.name), 32'(resp_bcond_o), 32'(v.e_bc));
    check($sformatf("%0d %s busy", idx, v.name), 32'(busy_o), 32'(|v.e_rv));
    @(negedge clk_i);
  endtask

  initial begin
    //   name        rst flush vld    rr     op0     a0            b0     op1     a1            b1    rdy    alu_a         rv     r0            r1     bc
    // Both requesters valid, pointer fresh from reset: 0,1,0,1
    add("alt0",     0, 0, 2'b11, 2'b11, OP_SUB, 32'd10,       32'd10, OP_LT,  32'hFFFFFFFF, 32'd1, 2'b01, 32'd10,       2'b01, 32'd0,        32'd0, 2'b01);
    add("alt1",     0, 0, 2'b11, 2'b11, OP_SUB, 32'd10,       32'd10, OP_LT,  32'hFFFFFFFF, 32'd1, 2'b10, 32'hFFFFFFFF, 2'b10, 32'd0,        32'd1, 2'b11);
    add("alt2",     0, 0, 2'b11, 2'b11, OP_SUB, 32'd10,       32'd10, OP_LT,  32'hFFFFFFFF, 32'd1, 2'b01, 32'd10,       2'b01, 32'd0,        32'd1, 2'b11);
    add("alt3",     0, 0, 2'b11, 2'b11, OP_SUB, 32'd10,       32'd10, OP_LT,  32'hFFFFFFFF, 32'd1, 2'b10, 32'hFFFFFFFF, 2'b10, 32'd0,        32'd1, 2'b11);
    // Requester 1 backpressured with a full slot
    add("bp0",      0, 0, 2'b11, 2'b01, OP_ADD, 32'd5,        32'd7,  OP_LT,  32'hFFFFFFFF, 32'd1, 2'b01, 32'd5,        2'b11, 32'd12,       32'd1, 2'b10);
    add("bp1",      0, 0, 2'b11, 2'b01, OP_ADD, 32'd5,        32'd7,  OP_LT,  32'hFFFFFFFF, 32'd1, 2'b01, 32'd5,        2'b11, 32'd12,       32'd1, 2'b10);
    add("bp2",      0, 0, 2'b11, 2'b01, OP_ADD, 32'd1,        32'd2,  OP_LT,  32'hFFFFFFFF, 32'd1, 2'b01, 32'd1,        2'b11, 32'd3,        32'd1, 2'b10);
    add("bp_rel",   0, 0, 2'b11, 2'b11, OP_ADD, 32'd1,        32'd2,  OP_LT,  32'd5,        32'd3, 2'b10, 32'd5,        2'b10, 32'd3,        32'd0, 2'b00);
    // Arithmetic shift uses b[4:0] only
    add("sra",      0, 0, 2'b01, 2'b11, OP_SRA, 32'h80000000, 32'h24, OP_ADD, 32'd0,        32'd0, 2'b01, 32'h80000000, 2'b01, 32'hF8000000, 32'd0, 2'b00);
    // Fill both slots, flush, then resume in prior order
    add("fill",     0, 0, 2'b11, 2'b00, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b10, 32'd1,        2'b11, 32'hF8000000, 32'd2, 2'b00);
    add("flush",    0, 1, 2'b11, 2'b00, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b00, 32'd0,        2'b00, 32'hF8000000, 32'd2, 2'b00);
    add("postfl",   0, 0, 2'b11, 2'b00, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b01, 32'd5,        2'b01, 32'd12,       32'd2, 2'b00);
    // Get both slots full with last_grant=0, then reset mid-operation
    add("prep1",    0, 0, 2'b10, 2'b00, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b10, 32'd1,        2'b11, 32'd12,       32'd2, 2'b00);
    add("prep0",    0, 0, 2'b01, 2'b01, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b01, 32'd5,        2'b11, 32'd12,       32'd2, 2'b00);
    add("rst_a",    1, 0, 2'b11, 2'b00, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b00, 32'd0,        2'b00, 32'd0,        32'd0, 2'b00);
    add("rst_b",    1, 0, 2'b11, 2'b00, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b00, 32'd0,        2'b00, 32'd0,        32'd0, 2'b00);
    add("post_rst", 0, 0, 2'b11, 2'b00, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b01, 32'd5,        2'b01, 32'd12,       32'd0, 2'b00);
    add("post_rs1", 0, 0, 2'b11, 2'b00, OP_ADD, 32'd5,        32'd7,  OP_ADD, 32'd1,        32'd1, 2'b10, 32'd1,        2'b11, 32'd12,       32'd2, 2'b00);

    // Reset with requests already valid: nothing may be accepted
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    req_valid_i  = 2'b11;
    resp_ready_i = 2'b00;
    req_op_i     = {OP_ADD, OP_ADD};
    req_a_i      = {32'd3, 32'd4};
    req_b_i      = {32'd3, 32'd4};
    @(negedge clk_i);
    check("reset ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("reset resp_valid", 32'(resp_valid_o), 32'd0);
    check("reset result", resp_result_o[31:0] | resp_result_o[63:32], 32'd0);
    check("reset bcond", 32'(resp_bcond_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_i       = 1'b0;
    req_valid_i = 2'b00;
    #1;
    check("idle ready", 32'(req_ready_o), 32'd0);
    check("idle alu_ctrl", 32'(alu_control_o), 32'(OP_ADD));
    check("idle alu_a", alu_a_o, 32'd0);
    check("idle alu_b", alu_b_o, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);

    // Single request from requester 0: ready same cycle, response next cycle
    req_valid_i  = 2'b01;
    resp_ready_i = 2'b00;
    req_op_i     = {OP_ADD, OP_ADD};
    req_a_i      = {32'd0, 32'd5};
    req_b_i      = {32'd0, 32'd7};
    #1;
    check("single ready", 32'(req_ready_o), 32'b01);
    check("single alu_b", alu_b_o, 32'd7);
    @(posedge clk_i);
    #1;
    check("single resp_valid", 32'(resp_valid_o), 32'b01);
    check("single result", resp_result_o[31:0], 32'd12);
    check("single bcond", 32'(resp_bcond_o), 32'b00);
    @(negedge clk_i);
    req_valid_i  = 2'b00;
    resp_ready_i = 2'b01;
    @(posedge clk_i);
    #1;
    check("single drained", 32'(resp_valid_o), 32'b00);
    @(negedge clk_i);

    // Pointer is back at 0 here; re-reset so the alternation starts at 0
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the core's single combinational ALU between NREQ requesters, e.g. the execute stage, the CSR unit and the debug/trace unit.
- Each requester sees a valid/ready request channel and a one-entry registered response channel.
- The block drives the ALU's control and operand inputs from the granted requester and captures result and bcond one cycle later.
- Selection is round-robin among eligible requesters.

Parameters:
NREQ, 2, number of requesters; supported range 2..4.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  synchronous clear of all pending responses
req_valid_i  in  NREQ  request valid, one bit per requester
req_ready_o  out  NREQ  request accepted this cycle, one-hot or zero
req_op_i  in  NREQ*ALU_CTRL_T_WIDTH  ALU control code per requester, riscv_pkg encoding
req_a_i  in  NREQ*32  operand a per requester
req_b_i  in  NREQ*32  operand b per requester
resp_valid_o  out  NREQ  response slot full
resp_ready_i  in  NREQ  requester consumes its response
resp_result_o  out  NREQ*32  registered ALU result per requester
resp_bcond_o  out  NREQ  registered branch condition per requester
alu_control_o  out  ALU_CTRL_T_WIDTH  to ALU control input
alu_a_o  out  32  to ALU operand a
alu_b_o  out  32  to ALU operand b
alu_result_i  in  32  from ALU result
alu_bcond_i  in  1  from ALU branch condition
busy_o  out  1  OR of resp_valid_o

Behaviour:
- Reset (rst_i=1 at an edge):
  - resp_valid_o=0, resp_result_o=0, resp_bcond_o=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has first priority.
  - req_ready_o=0 while rst_i is high.
- Eligibility: requester i is eligible when req_valid_i[i]=1 and (resp_valid_o[i]=0 or resp_ready_i[i]=1), i.e. its slot is empty or draining this cycle.
- Grant:
  - Combinational. Exactly one eligible requester is chosen, scanning from last_grant+1 modulo NREQ upward.
  - req_ready_o has only the winner's bit set; no grant when there are no eligible requesters, or when flush_i or rst_i is high.
  - req_ready_o may depend combinationally on req_valid_i and resp_ready_i. Requesters must not make valid depend on ready.
- ALU drive:
  - On grant, alu_control_o/alu_a_o/alu_b_o equal the winner's req_op/req_a/req_b.
  - With no grant, they are ADD_ALU_CONTROL, 0, 0.
- Capture:
  - On the grant edge, slot i loads alu_result_i and alu_bcond_i and sets resp_valid_o[i]=1.
  - Latency from accepted request to resp_valid_o is exactly 1 cycle.
  - Throughput is one request per cycle in aggregate, and one per cycle per requester if that requester holds resp_ready_i high.
- Pointer: last_grant updates to the winner only on a grant edge; otherwise it holds.
- Response hold:
  - Slot contents stay stable while resp_valid_o=1 and resp_ready_i=0.
  - When resp_ready_i=1 with no new grant to that slot, resp_valid_o clears at the edge.
- Simultaneous drain and grant on the same slot: the new result loads and resp_valid_o stays 1, with no bubble.
- Flush: at the edge with flush_i=1, all resp_valid_o clear, no grant occurs, and last_grant holds. Slot data need not clear.
- Reset mid-operation: pending responses are discarded, and a request presented with rst_i high is never accepted.
- Width rules:
  - resp_result_o is the unmodified 32-bit ALU result; no extension or truncation.
  - Requester k occupies bits [k*32+:32] of packed buses and [k*ALU_CTRL_T_WIDTH+:ALU_CTRL_T_WIDTH] of req_op_i.
- Fairness: a continuously eligible requester is granted within NREQ cycles.

Test Plan:
- Single request, requester 0:
  - Stimulus: ADD_ALU_CONTROL, a=5, b=7.
  - Response: req_ready_o=01 in the same cycle; next cycle resp_valid_o[0]=1, result=12, bcond=0.
- Both requesters valid every cycle with resp_ready high:
  - Requester 0 has SUB 10-10, requester 1 has LT_ALU_CONTROL a=0xFFFFFFFF, b=1.
  - Grants alternate 0,1,0,1 starting with 0.
  - Requester 0 gets result=0, bcond=1. Requester 1 gets result=1, bcond=1.
- Backpressure:
  - Stimulus: requester 1 holds resp_ready=0 with its slot full and keeps req_valid=1.
  - Response: requester 1 is never granted; requester 0 is granted every cycle; slot 1 data is stable.
  - Releasing ready for one cycle gives drain and new grant on the same edge, with no bubble.
- Shifts:
  - Stimulus: R_SHIFT_A_ALU_CONTROL a=0x80000000, b=0x24.
  - Response: result=0xF8000000 (shift amount 4 from b[4:0]).
- Flush:
  - Stimulus: flush_i pulsed while both slots are full and both requests are valid.
  - Response: resp_valid_o=00 next cycle; req_ready_o=00 during the flush cycle; the pointer is unchanged, so the next grant follows the prior order.
- Reset mid-operation:
  - Stimulus: assert rst_i with slots full and last_grant=0.
  - Response: resp_valid_o=00, req_ready_o=00 while rst_i is high, and the first grant after release goes to requester 0.
